decode_stage: RTL and testbench

//  RV32I instruction-decode stage with its ID/EX pipeline register. Takes the
//  IF/ID instruction, drives register-file read addresses, decodes control and

---
 rtl/rv32_pkg.sv | 65 ++++++
 rtl/imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 191 +++++++++++++++++++
 tb/tb_decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encoding, immediate formats
// and the ID/EX pipeline register layout.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic [2:0]  funct3;
        logic        illegal;
    } id_ex_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the immediate of the given format.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    // Format-selected immediate; inst[31] is always the sign bit
    always_comb begin
        imm = '0;
        case (fmt)
            FmtI:    imm = {{20{inst[31]}}, inst[31:20]};
            FmtS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FmtB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FmtU:    imm = {inst[31:12], 12'b0};
            FmtJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX pipeline register, load-use hazard
// detection, and flush/hold handling.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_out,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs1_data,
    output logic [XLEN-1:0] id_ex_rs2_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rs1,
    output logic [4:0]      id_ex_rs2,
    output logic [4:0]      id_ex_rd,
    output logic [3:0]      id_ex_alu_op,
    output logic            id_ex_alu_src,
    output logic            id_ex_mem_read,
    output logic            id_ex_mem_write,
    output logic            id_ex_reg_write,
    output logic            id_ex_branch,
    output logic            id_ex_jump,
    output logic [2:0]      id_ex_funct3,
    output logic            id_ex_illegal
);

    id_ex_t      dec;
    id_ex_t      id_ex_d;
    id_ex_t      id_ex_q;
    fmt_e        fmt;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        hz;

    assign rs1_addr = if_inst[19:15];
    assign rs2_addr = if_inst[24:20];

    imm_gen u_imm_gen (
        .inst (if_inst),
        .fmt  (fmt),
        .imm  (imm)
    );

    // Control decode; immediate is merged in at the register input
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1_addr;
        dec.rs2      = rs2_addr;
        dec.rd       = if_inst[11:7];
        dec.funct3   = if_inst[14:12];
        dec.alu_op   = ALU_ADD;
        fmt          = FmtI;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        case (if_inst[6:0])
            OP_OP: begin
                fmt           = FmtR;
                dec.alu_op    = alu_from_funct3(if_inst[14:12], if_inst[30]);
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_IMM: begin
                dec.alu_op    = alu_from_funct3(if_inst[14:12],
                                                (if_inst[14:12] == 3'b101) & if_inst[30]);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                fmt           = FmtS;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                fmt           = FmtB;
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_JAL: begin
                fmt           = FmtJ;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_LUI: begin
                fmt           = FmtU;
                dec.alu_op    = ALU_PASSB;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                fmt           = FmtU;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_FENCE: begin
                // Single-hart in-order pipe: fence needs no action
            end
            default: dec.illegal = 1'b1;  // includes SYSTEM (ECALL/EBREAK)
        endcase
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign hz = if_valid & ex_load_valid & (ex_load_rd != 5'd0) &
                ((use_rs1 & (ex_load_rd == rs1_addr)) | (use_rs2 & (ex_load_rd == rs2_addr)));

    assign stall_out = ~rst & (hz | hold);

    // ID/EX next state: flush > hold > hazard bubble > load decoded
    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d = '0;
        end else if (!hold) begin
            if (hz || !if_valid) begin
                id_ex_d = '0;
            end else begin
                id_ex_d     = dec;
                id_ex_d.imm = imm;
            end
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q    <= '0;
            id_ex_q.pc <= RESET_PC;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_valid     = id_ex_q.valid;
    assign id_ex_pc        = id_ex_q.pc;
    assign id_ex_rs1_data  = id_ex_q.rs1_data;
    assign id_ex_rs2_data  = id_ex_q.rs2_data;
    assign id_ex_imm       = id_ex_q.imm;
    assign id_ex_rs1       = id_ex_q.rs1;
    assign id_ex_rs2       = id_ex_q.rs2;
    assign id_ex_rd        = id_ex_q.rd;
    assign id_ex_alu_op    = id_ex_q.alu_op;
    assign id_ex_alu_src   = id_ex_q.alu_src;
    assign id_ex_mem_read  = id_ex_q.mem_read;
    assign id_ex_mem_write = id_ex_q.mem_write;
    assign id_ex_reg_write = id_ex_q.reg_write;
    assign id_ex_branch    = id_ex_q.branch;
    assign id_ex_jump      = id_ex_q.jump;
    assign id_ex_funct3    = id_ex_q.funct3;
    assign id_ex_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps plus randomized
// instructions scored against an instruction-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush, hold, stall_out;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic        id_ex_branch, id_ex_jump, id_ex_illegal;
    logic [2:0]  id_ex_funct3;

    decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .ex_load_valid   (ex_load_valid),
        .ex_load_rd      (ex_load_rd),
        .flush           (flush),
        .hold            (hold),
        .stall_out       (stall_out),
        .id_ex_valid     (id_ex_valid),
        .id_ex_pc        (id_ex_pc),
        .id_ex_rs1_data  (id_ex_rs1_data),
        .id_ex_rs2_data  (id_ex_rs2_data),
        .id_ex_imm       (id_ex_imm),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_alu_op    (id_ex_alu_op),
        .id_ex_alu_src   (id_ex_alu_src),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_mem_write (id_ex_mem_write),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_branch    (id_ex_branch),
        .id_ex_jump      (id_ex_jump),
        .id_ex_funct3    (id_ex_funct3),
        .id_ex_illegal   (id_ex_illegal)
    );

    always #5 clk = ~clk;

    // ALU codes as published for the EX stage
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7;
    localparam logic [3:0] A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
        logic [2:0]  funct3;
        bit          chk_data, chk_rs1, chk_rs2, chk_rd, chk_imm, chk_alu;
    } exp_t;

    exp_t        m;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] pc_ctr = 32'h1000;
    logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                              7'h33, 7'h0F, 7'h73, 7'h33};

    function automatic exp_t bubble();
        exp_t e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t reset_val();
        exp_t e = '{default: '0};
        e.chk_data = 1; e.chk_rs1 = 1; e.chk_rs2 = 1; e.chk_rd = 1; e.chk_imm = 1; e.chk_alu = 1;
        return e;
    endfunction

    function automatic logic [31:0] sext(input int unsigned v, input int unsigned bits);
        if (v >= (32'd1 << (bits - 1))) return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [3:0] alu_for(input int unsigned f3, input bit alt);
        case (f3)
            0: return alt ? A_SUB : A_ADD;
            1: return A_SLL;
            2: return A_SLT;
            3: return A_SLTU;
            4: return A_XOR;
            5: return alt ? A_SRA : A_SRL;
            6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic int unsigned opc(input logic [31:0] inst);
        int unsigned u = inst;
        return u & 127;
    endfunction

    function automatic bit model_hz(input logic v, input logic [31:0] inst,
                                    input logic lv, input logic [4:0] lrd);
        int unsigned u = inst;
        int unsigned o = opc(inst);
        bit r1 = (o == 'h33 || o == 'h13 || o == 'h03 || o == 'h23 || o == 'h63 || o == 'h67);
        bit r2 = (o == 'h33 || o == 'h23 || o == 'h63);
        return v && lv && lrd != 0 &&
               ((r1 && lrd == ((u >> 15) & 31)) || (r2 && lrd == ((u >> 20) & 31)));
    endfunction

    function automatic exp_t decode_model(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] d1, input logic [31:0] d2);
        exp_t e = '{default: '0};
        int unsigned u = inst;
        int unsigned f3 = (u >> 12) & 7;
        bit alt = ((u >> 30) & 1) != 0;
        int unsigned imm_i = sext(u >> 20, 12);
        int unsigned imm_s = sext((u >> 25) * 32 + ((u >> 7) & 31), 12);
        int unsigned imm_b = sext(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 +
                                  ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
        int unsigned imm_j = sext(((u >> 31) & 1) * (1 << 20) + ((u >> 12) & 255) * (1 << 12) +
                                  ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2, 21);
        e.valid = 1; e.pc = pc; e.rs1_data = d1; e.rs2_data = d2; e.chk_data = 1;
        e.rs1 = 5'((u >> 15) & 31); e.rs2 = 5'((u >> 20) & 31); e.rd = 5'((u >> 7) & 31);
        e.funct3 = 3'(f3);
        e.chk_imm = 1; e.chk_alu = 1; e.alu_op = A_ADD;
        case (opc(inst))
            'h33: begin e.alu_op = alu_for(f3, alt); e.reg_write = 1; e.chk_imm = 0;
                        e.chk_rs1 = 1; e.chk_rs2 = 1; e.chk_rd = 1; end
            'h13: begin e.alu_op = alu_for(f3, f3 == 5 && alt); e.alu_src = 1; e.reg_write = 1;
                        e.imm = imm_i; e.chk_rs1 = 1; e.chk_rd = 1; end
            'h03: begin e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.imm = imm_i;
                        e.chk_rs1 = 1; e.chk_rd = 1; end
            'h23: begin e.alu_src = 1; e.mem_write = 1; e.imm = imm_s;
                        e.chk_rs1 = 1; e.chk_rs2 = 1; end
            'h63: begin e.alu_op = A_SUB; e.branch = 1; e.imm = imm_b;
                        e.chk_rs1 = 1; e.chk_rs2 = 1; end
            'h6F: begin e.alu_src = 1; e.jump = 1; e.reg_write = 1; e.imm = imm_j;
                        e.chk_rd = 1; end
            'h67: begin e.alu_src = 1; e.jump = 1; e.reg_write = 1; e.imm = imm_i;
                        e.chk_rs1 = 1; e.chk_rd = 1; end
            'h37: begin e.alu_op = A_PASSB; e.alu_src = 1; e.reg_write = 1;
                        e.imm = u & 32'hFFFFF000; e.chk_rd = 1; end
            'h17: begin e.alu_src = 1; e.reg_write = 1; e.imm = u & 32'hFFFFF000;
                        e.chk_rd = 1; end
            'h0F: begin e.chk_imm = 0; e.chk_alu = 0; end
            default: begin e.illegal = 1; e.chk_imm = 0; e.chk_alu = 0; end
        endcase
        if (e.rd == 0) e.reg_write = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("valid", 32'(id_ex_valid), 32'(m.valid));
        chk("mem_read", 32'(id_ex_mem_read), 32'(m.mem_read));
        chk("mem_write", 32'(id_ex_mem_write), 32'(m.mem_write));
        chk("reg_write", 32'(id_ex_reg_write), 32'(m.reg_write));
        chk("branch", 32'(id_ex_branch), 32'(m.branch));
        chk("jump", 32'(id_ex_jump), 32'(m.jump));
        chk("illegal", 32'(id_ex_illegal), 32'(m.illegal));
        if (m.chk_data) begin
            chk("pc", id_ex_pc, m.pc);
            chk("rs1_data", id_ex_rs1_data, m.rs1_data);
            chk("rs2_data", id_ex_rs2_data, m.rs2_data);
        end
        if (m.chk_rs1) begin
            chk("rs1", 32'(id_ex_rs1), 32'(m.rs1));
            chk("funct3", 32'(id_ex_funct3), 32'(m.funct3));
        end
        if (m.chk_rs2) chk("rs2", 32'(id_ex_rs2), 32'(m.rs2));
        if (m.chk_rd) chk("rd", 32'(id_ex_rd), 32'(m.rd));
        if (m.chk_imm) chk("imm", id_ex_imm, m.imm);
        if (m.chk_alu) begin
            chk("alu_op", 32'(id_ex_alu_op), 32'(m.alu_op));
            chk("alu_src", 32'(id_ex_alu_src), 32'(m.alu_src));
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, check ID/EX
    task automatic step(input logic v, input logic [31:0] inst, input logic lv,
                        input logic [4:0] lrd, input logic fl, input logic ho);
        bit hz_m;
        if_valid = v; if_inst = inst; if_pc = pc_ctr; pc_ctr += 4;
        rs1_data = $urandom; rs2_data = $urandom;
        ex_load_valid = lv; ex_load_rd = lrd; flush = fl; hold = ho;
        #1;
        hz_m = model_hz(v, inst, lv, lrd);
        chk("stall_out", 32'(stall_out), 32'(hz_m | ho));
        chk("rs1_addr", 32'(rs1_addr), 32'(inst[19:15]));
        chk("rs2_addr", 32'(rs2_addr), 32'(inst[24:20]));
        @(posedge clk);
        if (fl) m = bubble();
        else if (!ho) begin
            if (hz_m || !v) m = bubble();
            else m = decode_model(inst, if_pc, rs1_data, rs2_data);
        end
        #1;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [31:0] inst;
        logic [4:0]  lrd;

        // Reset: stall_out held low even with hold asserted
        rst = 1; if_valid = 0; if_inst = 0; if_pc = 0; rs1_data = 0; rs2_data = 0;
        ex_load_valid = 0; ex_load_rd = 0; flush = 0; hold = 1;
        #2;
        m = reset_val();
        check_state();
        chk("reset_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        hold = 0;
        rst = 0;

        // addi x1,x0,5
        step(1, 32'h00500093, 0, 0, 0, 0);
        chk("t1_imm", id_ex_imm, 32'd5);
        chk("t1_rd", 32'(id_ex_rd), 32'd1);
        chk("t1_alu", 32'(id_ex_alu_op), 32'(A_ADD));

        // sw x2,-4(x1)
        step(1, 32'hFE20AE23, 0, 0, 0, 0);
        chk("t2_imm", id_ex_imm, 32'hFFFFFFFC);
        chk("t2_mw", 32'(id_ex_mem_write), 32'd1);

        // Load-use on add x3,x2,x2, then the add proceeds
        step(1, 32'h002101B3, 1, 5'd2, 0, 0);
        chk("t3_bubble", 32'(id_ex_valid), 32'd0);
        step(1, 32'h002101B3, 0, 0, 0, 0);
        chk("t3_rd", 32'(id_ex_rd), 32'd3);

        // Hold for three cycles keeps the registered addi
        step(1, 32'h00500093, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'hFE20AE23, 0, 0, 0, 1);
        chk("t4_hold_imm", id_ex_imm, 32'd5);

        // Flush wins over hold
        step(1, 32'h00500093, 0, 0, 1, 1);
        chk("t4_flush", 32'(id_ex_valid), 32'd0);

        // Illegal word, then addi to x0
        step(1, 32'hFFFFFFFF, 0, 0, 0, 0);
        chk("t5_illegal", 32'(id_ex_illegal), 32'd1);
        step(1, 32'h00100013, 0, 0, 0, 0);
        chk("t5_rw_x0", 32'(id_ex_reg_write), 32'd0);

        // if_valid low loads a bubble
        step(0, 32'h00500093, 0, 0, 0, 0);

        // Asynchronous reset between edges
        step(1, 32'h00500093, 0, 0, 0, 0);
        #2; rst = 1; #1;
        m = reset_val();
        check_state();
        @(posedge clk); #1;
        check_state();
        rst = 0;
        step(1, 32'h00500093, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) inst[6:0] = 7'($urandom);
            case ($urandom_range(0, 3))
                0: lrd = inst[19:15];
                1: lrd = inst[24:20];
                2: lrd = 5'($urandom);
                default: lrd = 5'd0;
            endcase
            step(1'($urandom_range(0, 7) != 0), inst, 1'($urandom_range(0, 2) == 0), lrd,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
